// File: rtl/ctmm_pkg.sv
// Shared types for the CTMM exclusive-access scheduler.
// Fault codes, op encoding, FSM states and operand bundle.
package ctmm_pkg;

    typedef enum logic [3:0] {
        FAULT_NONE    = 4'd0,
        FAULT_PERM_L  = 4'd1,
        FAULT_PERM_S  = 4'd2,
        FAULT_BOUNDS  = 4'd3,
        FAULT_SEAL    = 4'd4,
        FAULT_TIMEOUT = 4'd5
    } fault_type_t;

    typedef enum logic {
        EXCL_OP_LOADX = 1'b0,
        EXCL_OP_SAVEX = 1'b1
    } excl_op_t;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ISSUE = 3'd1,
        S_WAIT  = 3'd2,
        S_RUN   = 3'd3,
        S_RESP  = 3'd4
    } excl_state_t;

    localparam int CR_W  = 3;
    localparam int OFF_W = 10;
    localparam int DR_W  = 4;
    localparam int TID_W = 4;

    typedef struct packed {
        excl_op_t           op;
        logic [CR_W-1:0]    cr_src;
        logic [CR_W-1:0]    cr_base;
        logic [CR_W-1:0]    cr_dst;
        logic [OFF_W-1:0]   offset;
        logic [DR_W-1:0]    result_dr;
        logic [TID_W-1:0]   thread_id;
    } excl_opr_t;

    function automatic logic is_active(excl_state_t s);
        return (s == S_WAIT) || (s == S_RUN);
    endfunction

endpackage

// File: rtl/ctmm_rr_arbiter.sv
// Combinational round-robin arbiter: grants the first
// request at or after ptr, wrapping cyclically.
module ctmm_rr_arbiter #(
    parameter int N = 4
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] ptr,
    output logic [N-1:0]         gnt
);

    localparam int PW = $clog2(N);

    logic            found;
    logic [PW:0]     sum;
    logic [PW-1:0]   idx;

    always_comb begin
        gnt   = '0;
        found = 1'b0;
        sum   = '0;
        idx   = '0;
        for (int i = 0; i < N; i++) begin
            sum = {1'b0, ptr} + (PW+1)'(i);
            if (sum >= (PW+1)'(N)) begin
                sum = sum - (PW+1)'(N);
            end
            idx = sum[PW-1:0];
            if (!found && req[idx]) begin
                gnt[idx] = 1'b1;
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ctmm_excl_sched.sv
// Round-robin scheduler of LOADX/SAVEX requests onto one
// shared unit, with fault routing, watchdog and snoop regs.
module ctmm_excl_sched
    import ctmm_pkg::*;
#(
    parameter int NUM_REQ     = 4,
    parameter int TIMEOUT_CYC = 256
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [NUM_REQ-1:0]   req_op,
    input  logic [NUM_REQ*3-1:0] req_cr_src,
    input  logic [NUM_REQ*3-1:0] req_cr_base,
    input  logic [NUM_REQ*3-1:0] req_cr_dst,
    input  logic [NUM_REQ*10-1:0] req_offset,
    input  logic [NUM_REQ*4-1:0] req_result_dr,
    input  logic [NUM_REQ*4-1:0] req_thread_id,
    output logic [NUM_REQ-1:0]   req_ack,
    output logic [NUM_REQ-1:0]   rsp_valid,
    output logic                 rsp_fault,
    output fault_type_t          rsp_fault_type,
    output logic                 ux_loadx_start,
    output logic                 ux_savex_start,
    output logic [2:0]           ux_cr_src,
    output logic [2:0]           ux_cr_base,
    output logic [2:0]           ux_cr_dst,
    output logic [9:0]           ux_offset,
    output logic [3:0]           ux_result_dr,
    output logic [3:0]           ux_thread_id,
    input  logic                 ux_busy,
    input  logic                 ux_complete,
    input  logic                 ux_fault_valid,
    input  fault_type_t          ux_fault_type,
    input  logic                 snp_valid,
    input  logic [31:0]          snp_addr,
    output logic                 ux_ext_addr_match,
    output logic [31:0]          ux_ext_access_addr
);

    localparam int IW = $clog2(NUM_REQ);
    localparam int WW = $clog2(TIMEOUT_CYC);

    excl_state_t  state_q;
    excl_state_t  state_d;
    logic [IW-1:0] ptr_q;
    logic [IW-1:0] gidx_q;
    logic [IW-1:0] gidx_d;
    logic [NUM_REQ-1:0] gnt;
    excl_opr_t    opr_q;
    excl_opr_t    cap;
    logic         flt_q;
    fault_type_t  flt_type_q;
    logic [WW-1:0] wd_q;
    logic         any_req;
    logic         grant;
    logic         timeout;
    logic         unused_ok;

    assign unused_ok = ux_complete;
    assign any_req   = |req_valid;
    assign grant     = (state_q == S_IDLE) && any_req;

    ctmm_rr_arbiter #(
        .N (NUM_REQ)
    ) u_arb (
        .req (req_valid),
        .ptr (ptr_q),
        .gnt (gnt)
    );

    always_comb begin
        gidx_d = '0;
        cap    = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt[i]) begin
                gidx_d        = IW'(i);
                cap.op        = excl_op_t'(req_op[i]);
                cap.cr_src    = req_cr_src[i*3 +: 3];
                cap.cr_base   = req_cr_base[i*3 +: 3];
                cap.cr_dst    = req_cr_dst[i*3 +: 3];
                cap.offset    = req_offset[i*10 +: 10];
                cap.result_dr = req_result_dr[i*4 +: 4];
                cap.thread_id = req_thread_id[i*4 +: 4];
            end
        end
    end

    // ISSUE clears the count, so an abort's RESP lands
    // exactly TIMEOUT_CYC cycles after the start pulse.
    assign timeout = is_active(state_q)
                  && (wd_q == WW'(TIMEOUT_CYC - 2));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (any_req) state_d = S_ISSUE;
            end
            S_ISSUE: state_d = S_WAIT;
            S_WAIT: begin
                if (timeout)      state_d = S_RESP;
                else if (ux_busy) state_d = S_RUN;
            end
            S_RUN: begin
                if (timeout || !ux_busy) state_d = S_RESP;
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        req_ack        = '0;
        rsp_valid      = '0;
        rsp_fault      = 1'b0;
        rsp_fault_type = FAULT_NONE;
        ux_loadx_start = 1'b0;
        ux_savex_start = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (!rst) req_ack = gnt;
            end
            S_ISSUE: begin
                ux_loadx_start = (opr_q.op == EXCL_OP_LOADX);
                ux_savex_start = (opr_q.op == EXCL_OP_SAVEX);
            end
            S_RESP: begin
                rsp_valid      = NUM_REQ'(1) << gidx_q;
                rsp_fault      = flt_q;
                rsp_fault_type = flt_type_q;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q  <= '0;
            gidx_q <= '0;
            opr_q  <= '0;
        end else if (grant) begin
            gidx_q <= gidx_d;
            opr_q  <= cap;
            ptr_q  <= (gidx_d == IW'(NUM_REQ - 1))
                    ? '0 : gidx_d + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wd_q <= '0;
        end else if (state_q == S_ISSUE) begin
            wd_q <= '0;
        end else if (is_active(state_q)) begin
            wd_q <= wd_q + 1'b1;
        end
    end

    // First fault wins; a watchdog abort overrides it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flt_q      <= 1'b0;
            flt_type_q <= FAULT_NONE;
        end else if (state_q == S_ISSUE) begin
            flt_q      <= 1'b0;
            flt_type_q <= FAULT_NONE;
        end else if (timeout) begin
            flt_q      <= 1'b1;
            flt_type_q <= FAULT_TIMEOUT;
        end else if ((state_q == S_RUN) && ux_busy
                     && ux_fault_valid && !flt_q) begin
            flt_q      <= 1'b1;
            flt_type_q <= ux_fault_type;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ux_ext_addr_match  <= 1'b0;
            ux_ext_access_addr <= '0;
        end else begin
            ux_ext_addr_match  <= snp_valid;
            ux_ext_access_addr <= snp_addr;
        end
    end

    assign ux_cr_src    = opr_q.cr_src;
    assign ux_cr_base   = opr_q.cr_base;
    assign ux_cr_dst    = opr_q.cr_dst;
    assign ux_offset    = opr_q.offset;
    assign ux_result_dr = opr_q.result_dr;
    assign ux_thread_id = opr_q.thread_id;

endmodule

// File: tb/tb_ctmm_excl_sched.sv
// Randomized scoreboard bench for ctmm_excl_sched with a
// behavioural unit model, requester model and snoop checker.
module tb_ctmm_excl_sched;
    import ctmm_pkg::*;

    localparam int N  = 4;
    localparam int TO = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [N-1:0]    req_valid, req_op;
    logic [N*3-1:0]  req_cr_src, req_cr_base, req_cr_dst;
    logic [N*10-1:0] req_offset;
    logic [N*4-1:0]  req_result_dr, req_thread_id;
    logic [N-1:0]    req_ack, rsp_valid;
    logic            rsp_fault;
    fault_type_t     rsp_fault_type;
    logic            ux_loadx_start, ux_savex_start;
    logic [2:0]      ux_cr_src, ux_cr_base, ux_cr_dst;
    logic [9:0]      ux_offset;
    logic [3:0]      ux_result_dr, ux_thread_id;
    logic            ux_busy, ux_complete, ux_fault_valid;
    fault_type_t     ux_fault_type;
    logic            snp_valid;
    logic [31:0]     snp_addr;
    logic            ux_ext_addr_match;
    logic [31:0]     ux_ext_access_addr;

    always #5 clk = ~clk;

    ctmm_excl_sched #(
        .NUM_REQ     (N),
        .TIMEOUT_CYC (TO)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .req_valid          (req_valid),
        .req_op             (req_op),
        .req_cr_src         (req_cr_src),
        .req_cr_base        (req_cr_base),
        .req_cr_dst         (req_cr_dst),
        .req_offset         (req_offset),
        .req_result_dr      (req_result_dr),
        .req_thread_id      (req_thread_id),
        .req_ack            (req_ack),
        .rsp_valid          (rsp_valid),
        .rsp_fault          (rsp_fault),
        .rsp_fault_type     (rsp_fault_type),
        .ux_loadx_start     (ux_loadx_start),
        .ux_savex_start     (ux_savex_start),
        .ux_cr_src          (ux_cr_src),
        .ux_cr_base         (ux_cr_base),
        .ux_cr_dst          (ux_cr_dst),
        .ux_offset          (ux_offset),
        .ux_result_dr       (ux_result_dr),
        .ux_thread_id       (ux_thread_id),
        .ux_busy            (ux_busy),
        .ux_complete        (ux_complete),
        .ux_fault_valid     (ux_fault_valid),
        .ux_fault_type      (ux_fault_type),
        .snp_valid          (snp_valid),
        .snp_addr           (snp_addr),
        .ux_ext_addr_match  (ux_ext_addr_match),
        .ux_ext_access_addr (ux_ext_access_addr)
    );

    typedef struct {
        logic [N-1:0] ack;
        bit           op;
        logic [26:0]  opr;
        bit           flt;
        logic [3:0]   ftype;
        bit           hang;
    } exp_t;

    typedef struct {
        int          d1;
        int          d2;
        bit          flt;
        fault_type_t ftype;
        int          fpos;
        bit          hang;
    } ucfg_t;

    exp_t  exp_q[$];
    ucfg_t unit_q[$];

    int checks   = 0;
    int failures = 0;

    bit         op_f[N];
    logic [2:0] src_f[N], base_f[N], dst_f[N];
    logic [9:0] off_f[N];
    logic [3:0] rdr_f[N], tid_f[N];
    logic [N-1:0] pend = '0;
    int  ptr_m   = 0;
    bit  m_infl  = 1'b0;
    int  snp_dir = 0;

    task automatic chk(input string name,
                       input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h",
                     name, act, exp);
        end
    endtask

    task automatic pack_bus();
        for (int i = 0; i < N; i++) begin
            req_op[i]               = op_f[i];
            req_cr_src[i*3 +: 3]    = src_f[i];
            req_cr_base[i*3 +: 3]   = base_f[i];
            req_cr_dst[i*3 +: 3]    = dst_f[i];
            req_offset[i*10 +: 10]  = off_f[i];
            req_result_dr[i*4 +: 4] = rdr_f[i];
            req_thread_id[i*4 +: 4] = tid_f[i];
        end
        req_valid = pend;
    endtask

    task automatic rand_fields(input int i);
        op_f[i]   = 1'($urandom_range(0, 1));
        src_f[i]  = 3'($urandom);
        base_f[i] = 3'($urandom);
        dst_f[i]  = 3'($urandom);
        off_f[i]  = 10'($urandom);
        rdr_f[i]  = 4'($urandom);
        tid_f[i]  = 4'($urandom);
    endtask

    function automatic ucfg_t rand_cfg(input bit allow_hang);
        ucfg_t c;
        c.d1    = $urandom_range(0, 2);
        c.d2    = $urandom_range(1, 5);
        c.flt   = ($urandom_range(0, 9) < 3);
        c.ftype = fault_type_t'(4'($urandom_range(1, 4)));
        c.fpos  = $urandom_range(0, c.d2 - 1);
        c.hang  = allow_hang && ($urandom_range(0, 11) == 0);
        return c;
    endfunction

    // Reference arbitration: first pending slot at or after ptr.
    function automatic int winner(input logic [N-1:0] m,
                                  input int p);
        for (int k = 0; k < N; k++) begin
            int j;
            j = (p + k) % N;
            if (m[j]) return j;
        end
        return -1;
    endfunction

    task automatic push_txn(input ucfg_t c, output int g);
        exp_t e;
        g       = winner(pend, ptr_m);
        e.ack   = N'(1) << g;
        e.op    = op_f[g];
        e.opr   = {src_f[g], base_f[g], dst_f[g],
                   off_f[g], rdr_f[g], tid_f[g]};
        e.hang  = c.hang;
        e.flt   = c.hang || c.flt;
        e.ftype = c.hang ? FAULT_TIMEOUT
                : (c.flt ? c.ftype : FAULT_NONE);
        exp_q.push_back(e);
        unit_q.push_back(c);
        ptr_m = (g + 1) % N;
    endtask

    task automatic wait_ack();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (req_ack == '0 && n < 200);
        chk("ack_wait", 64'(req_ack != '0), 1);
    endtask

    task automatic do_txn(input ucfg_t c, input bit keep);
        int g;
        push_txn(c, g);
        pack_bus();
        wait_ack();
        @(posedge clk);
        #2;
        if (keep) rand_fields(g);
        else      pend[g] = 1'b0;
        pack_bus();
    endtask

    task automatic chk_reset_outs();
        chk("rst_ctl", {req_ack, rsp_valid, rsp_fault,
                        rsp_fault_type, ux_loadx_start,
                        ux_savex_start, ux_ext_addr_match}, 0);
        chk("rst_opr", {ux_cr_src, ux_cr_base, ux_cr_dst,
                        ux_offset, ux_result_dr,
                        ux_thread_id}, 0);
        chk("rst_snp_addr", ux_ext_access_addr, 0);
    endtask

    task automatic wait_busy();
        int n = 0;
        while (!ux_busy && n < 50) begin
            @(posedge clk);
            #2;
            n++;
        end
        chk("busy_wait", 64'(ux_busy), 1);
    endtask

    // Behavioural shared unit, configured per operation.
    initial begin
        ucfg_t c;
        int wc, rc;
        bit act;
        act = 1'b0; wc = 0; rc = 0;
        c = rand_cfg(1'b0);
        ux_busy = 1'b0; ux_complete = 1'b0;
        ux_fault_valid = 1'b0; ux_fault_type = FAULT_NONE;
        forever begin
            @(negedge clk);
            ux_fault_valid = 1'b0;
            ux_fault_type  = FAULT_NONE;
            ux_complete    = 1'b0;
            if (rst) begin
                act = 1'b0; ux_busy = 1'b0;
            end else if (ux_loadx_start || ux_savex_start) begin
                if (unit_q.size() > 0) begin
                    c = unit_q.pop_front();
                    act = 1'b1; wc = c.d1; rc = c.d2;
                end
                ux_busy = 1'b0;
            end else if (rsp_valid != '0) begin
                act = 1'b0; ux_busy = 1'b0;
            end else if (act) begin
                if (wc > 0) wc--;
                else if (!ux_busy) ux_busy = 1'b1;
                else if (c.hang) ;
                else if (rc == 0) begin
                    ux_busy = 1'b0; act = 1'b0;
                    ux_complete = 1'b1;
                end else begin
                    rc--;
                    if (c.flt && rc == c.fpos) begin
                        ux_fault_valid = 1'b1;
                        ux_fault_type  = c.ftype;
                    end
                end
            end
        end
    end

    // Snoop stimulus and one-cycle-latency checker.
    initial begin
        logic pv;
        logic [31:0] pa;
        bit prev_rst;
        pv = 1'b0; pa = '0; prev_rst = 1'b1;
        snp_valid = 1'b0; snp_addr = '0;
        forever begin
            @(negedge clk);
            if (!rst && !prev_rst) begin
                chk("snp_match", 64'(ux_ext_addr_match), 64'(pv));
                chk("snp_addr", ux_ext_access_addr, pa);
            end
            prev_rst = rst;
            if (snp_dir == 2) begin
                snp_valid = 1'b1; snp_addr = 32'h1000;
            end else if (snp_dir == 1) begin
                snp_valid = 1'b0; snp_addr = $urandom;
            end else begin
                snp_valid = ($urandom_range(0, 2) == 0);
                snp_addr  = $urandom;
            end
            if (snp_dir > 0) snp_dir--;
            pv = snp_valid; pa = snp_addr;
        end
    end

    // Monitor: pops expectations as the DUT responds.
    initial begin
        exp_t cur;
        int starts, ack_c, st_c, cyc;
        bit unstable;
        logic [26:0] opr_now;
        starts = 0; ack_c = 0; st_c = 0; cyc = 0;
        unstable = 1'b0;
        cur = '{default: '0};
        forever begin
            @(negedge clk);
            cyc++;
            opr_now = {ux_cr_src, ux_cr_base, ux_cr_dst,
                       ux_offset, ux_result_dr, ux_thread_id};
            if (!rst) begin
                if (req_ack != '0) begin
                    chk("ack_while_busy", 64'(m_infl), 0);
                    if (exp_q.size() == 0) begin
                        chk("ack_unexpected", req_ack, 0);
                    end else begin
                        cur = exp_q.pop_front();
                        chk("ack_mask", req_ack, cur.ack);
                        m_infl = 1'b1; starts = 0;
                        ack_c = cyc; unstable = 1'b0;
                    end
                end
                if (ux_loadx_start || ux_savex_start) begin
                    chk("start_inflight", 64'(m_infl), 1);
                    starts++;
                    st_c = cyc;
                    chk("start_latency", 64'(cyc - ack_c), 1);
                    chk("start_op",
                        {ux_savex_start, ux_loadx_start},
                        cur.op ? 2'b10 : 2'b01);
                    chk("operands", opr_now, cur.opr);
                end else if (m_infl && starts > 0
                             && opr_now !== cur.opr) begin
                    unstable = 1'b1;
                end
                if (rsp_valid != '0) begin
                    chk("rsp_inflight", 64'(m_infl), 1);
                    chk("rsp_mask", rsp_valid, cur.ack);
                    chk("rsp_fault", 64'(rsp_fault), 64'(cur.flt));
                    chk("rsp_type", rsp_fault_type, cur.ftype);
                    chk("start_count", 64'(starts), 1);
                    chk("opr_stable", 64'(unstable), 0);
                    if (cur.hang)
                        chk("timeout_lat", 64'(cyc - st_c), TO);
                    m_infl = 1'b0;
                end else if (rsp_fault) begin
                    chk("rsp_fault_idle", 64'(rsp_fault), 0);
                end
            end
        end
    end

    initial begin
        ucfg_t c;
        int g, n;
        for (int i = 0; i < N; i++) rand_fields(i);
        pack_bus();
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_reset_outs();
        @(posedge clk);
        #2;
        rst = 1'b0;

        // Single LOADX from slot 0.
        op_f[0] = 1'b0; src_f[0] = 3'd1; base_f[0] = 3'd2;
        dst_f[0] = 3'd5; off_f[0] = 10'd3;
        rdr_f[0] = 4'd7; tid_f[0] = 4'd9;
        pend = 4'b0001;
        c = '{d1: 1, d2: 3, flt: 1'b0, ftype: FAULT_NONE,
              fpos: 0, hang: 1'b0};
        do_txn(c, 1'b0);

        // SAVEX from slot 2 with a permission fault, plus snoop.
        rand_fields(2);
        op_f[2] = 1'b1;
        pend = 4'b0100;
        c = '{d1: 1, d2: 4, flt: 1'b1, ftype: FAULT_PERM_S,
              fpos: 2, hang: 1'b0};
        do_txn(c, 1'b0);
        wait_busy();
        snp_dir = 2;

        // Hung unit from slot 3 leaves the pointer at 0.
        rand_fields(3);
        pend = 4'b1000;
        c = rand_cfg(1'b0);
        c.hang = 1'b1;
        do_txn(c, 1'b0);

        // All slots held: expect 0,1,2,3,0.
        for (int i = 0; i < N; i++) rand_fields(i);
        pend = 4'b1111;
        for (int k = 0; k < 5; k++) do_txn(rand_cfg(1'b0), k < 4);

        for (int t = 0; t < 40; t++) begin
            logic [N-1:0] nb;
            nb = N'($urandom) & ~pend;
            if ((pend | nb) == '0) nb = N'(1) << $urandom_range(0, N-1);
            for (int i = 0; i < N; i++) if (nb[i]) rand_fields(i);
            pend = pend | nb;
            do_txn(rand_cfg(1'b1), $urandom_range(0, 3) == 0);
        end
        n = 0;
        while (pend != '0 && n < 8) begin
            do_txn(rand_cfg(1'b0), 1'b0);
            n++;
        end

        // Reset during RUN, then the held request is re-granted.
        rand_fields(0);
        pend = 4'b0001;
        c = rand_cfg(1'b0);
        c.hang = 1'b1;
        push_txn(c, g);
        pack_bus();
        wait_ack();
        wait_busy();
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b1;
        @(negedge clk);
        chk_reset_outs();
        @(posedge clk);
        #2;
        exp_q.delete();
        unit_q.delete();
        m_infl = 1'b0;
        ptr_m  = 0;
        push_txn(rand_cfg(1'b0), g);
        rst = 1'b0;
        wait_ack();
        @(posedge clk);
        #2;
        pend = '0;
        pack_bus();

        n = 0;
        while ((exp_q.size() != 0 || m_infl) && n < 300) begin
            @(posedge clk);
            n++;
        end
        chk("drain", 64'(exp_q.size() == 0 && !m_infl), 1);
        repeat (3) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d",
                 checks, failures);
        $finish;
    end

endmodule
